// File: rtl/mem_access_unit.sv
// Memory stage: load/store/LR/SC/AMO over a single-outstanding request/response bus.
// Optional MEM_ACCESS_RSV_SNOOP_EN: stores/AMOs hitting the reserved granule cancel the reservation.
module mem_access_unit #(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int RSV_GRAN_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic                is_new,
  input  logic [2:0]          mem_op,
  input  logic [1:0]          mem_size,
  input  logic                is_unsigned,
  input  logic [3:0]          amo_fn,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     wdata,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_wen,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [XLEN-1:0]     req_wdata,
  output logic [XLEN/8-1:0]   req_wstrb,
  input  logic                resp_valid,
  input  logic [XLEN-1:0]     resp_rdata,
  output logic [XLEN-1:0]     rdata,
  output logic                stall,
  output logic                trap_valid,
  output logic [3:0]          trap_cause,
  output logic                rsv_valid
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(XLEN);
  localparam int GW   = ADDR_W - RSV_GRAN_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_FIN} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_LOAD, OP_STORE, OP_LR, OP_SC, OP_AMO} op_t;
  typedef enum logic [3:0] {FN_SWAP, FN_ADD, FN_XOR, FN_AND, FN_OR, FN_MIN, FN_MAX} amo_fn_t;

  state_t            state, state_nxt;
  logic              done, drain, amo_wr;
  logic [XLEN-1:0]   wbuf;
  logic [GW-1:0]     rsv_addr;

  logic [1:0]        sz;
  logic [OFFW-1:0]   off;
  logic              misaligned, op_live, eligible, read_op, wr_phase, sc_match, snoop_hit;
  logic [GW-1:0]     rsv_gran;
  logic [XLEN-1:0]   shifted, ld_val, amo_src, amo_res;
  logic              amo_lt;
  logic [3:0]        strb_lo, strb_hi;

  // Sign/zero-extend the low 8<<s bits of v.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic [1:0] s,
                                          input logic u);
    logic [XLEN-1:0] r;
    logic [IW-1:0]   msb;
    logic            sb;
    msb = IW'((32'd8 << s) - 32'd1);
    sb  = ~u & v[msb];
    for (int unsigned i = 0; i < XLEN; i++) r[i] = (i < (32'd8 << s)) ? v[i] : sb;
    return r;
  endfunction

  always_comb begin
    sz = (XLEN == 32 && mem_size == 2'd3) ? 2'd2 : mem_size;
    off = addr[OFFW-1:0];
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
    op_live  = (mem_op != OP_NONE) && (mem_op <= OP_AMO);
    eligible = valid && op_live && (!done || is_new);
    read_op  = (mem_op == OP_LOAD) || (mem_op == OP_LR);
    wr_phase = amo_wr || (mem_op == OP_STORE) || (mem_op == OP_SC);
    rsv_gran = addr[ADDR_W-1:RSV_GRAN_LOG2];
    sc_match = rsv_valid && (rsv_addr == rsv_gran);
  end

`ifdef MEM_ACCESS_RSV_SNOOP_EN
  assign snoop_hit = (state == S_REQ) && req_ready && wr_phase && (mem_op != OP_SC)
                     && (rsv_gran == rsv_addr);
`else
  assign snoop_hit = 1'b0;
`endif

  // Load extraction and AMO arithmetic; AMO operands are always sign-extended.
  always_comb begin
    shifted = resp_rdata >> {off, 3'b000};
    ld_val  = ext(shifted, sz, is_unsigned && (mem_op != OP_AMO));
    amo_src = ext(wdata, sz, 1'b0);
    amo_lt  = is_unsigned ? (ld_val < amo_src) : ($signed(ld_val) < $signed(amo_src));
    case (amo_fn)
      FN_SWAP: amo_res = amo_src;
      FN_ADD:  amo_res = ld_val + amo_src;
      FN_XOR:  amo_res = ld_val ^ amo_src;
      FN_AND:  amo_res = ld_val & amo_src;
      FN_OR:   amo_res = ld_val | amo_src;
      FN_MIN:  amo_res = amo_lt ? ld_val : amo_src;
      FN_MAX:  amo_res = amo_lt ? amo_src : ld_val;
      default: amo_res = amo_src;
    endcase
  end

  always_comb begin
    req_wen   = wr_phase;
    req_addr  = {addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    req_wdata = (amo_wr ? wbuf : wdata) << {off, 3'b000};
    strb_lo   = 4'(off);
    strb_hi   = strb_lo + (4'd1 << sz);
    for (int unsigned i = 0; i < NB; i++)
      req_wstrb[i] = (4'(i) >= strb_lo) && (4'(i) < strb_hi);
  end

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    trap_valid = 1'b0;
    trap_cause = '0;
    req_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (eligible) begin
          if (misaligned) begin
            trap_valid = 1'b1;
            trap_cause = read_op ? 4'd4 : 4'd6;
          end else begin
            stall     = 1'b1;
            state_nxt = (mem_op == OP_SC && !sc_match) ? S_FIN : S_REQ;
          end
        end
      end
      S_REQ: begin
        req_valid = 1'b1;
        stall     = valid;
        if (req_ready) begin
          if (!wr_phase)   state_nxt = S_RESP;
          else if (valid)  state_nxt = S_FIN;
          else             state_nxt = S_IDLE;
        end else if (!valid) begin
          state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        // A flushed read still owns the bus until its response arrives.
        stall = valid;
        if (resp_valid) begin
          if (drain || !valid)                     state_nxt = S_IDLE;
          else if (mem_op == OP_AMO && !amo_wr)    state_nxt = S_REQ;
          else                                     state_nxt = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      drain     <= 1'b0;
      amo_wr    <= 1'b0;
      wbuf      <= '0;
      rdata     <= '0;
      rsv_valid <= 1'b0;
      rsv_addr  <= '0;
    end else begin
      state <= state_nxt;
      drain <= (state_nxt == S_RESP) && (drain || !valid);

      if (state == S_FIN) done <= 1'b1;
      else if (state == S_IDLE && (is_new || !valid)) done <= 1'b0;

      if (state == S_IDLE) amo_wr <= 1'b0;
      else if (state == S_RESP && state_nxt == S_REQ) amo_wr <= 1'b1;

      if (state == S_IDLE && eligible && !misaligned && mem_op == OP_SC) begin
        rsv_valid <= 1'b0;
        if (!sc_match) rdata <= XLEN'(1);
      end

      if (state == S_REQ && req_ready) begin
        if (wr_phase) begin
          if (!amo_wr) rdata <= '0;
        end else if (mem_op == OP_LR && valid) begin
          rsv_valid <= 1'b1;
          rsv_addr  <= rsv_gran;
        end
      end

      if (snoop_hit) rsv_valid <= 1'b0;

      if (state == S_RESP && resp_valid && valid && !drain) begin
        rdata <= ld_val;
        wbuf  <= amo_res;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32): loads, stores, traps, LR/SC, AMO, flush, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n, valid, is_new, is_unsigned;
  logic [2:0]  mem_op;
  logic [1:0]  mem_size;
  logic [3:0]  amo_fn;
  logic [31:0] addr, wdata;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata, rdata;
  logic        stall, trap_valid, rsv_valid;
  logic [3:0]  trap_cause;

  int checks = 0;
  int errors = 0;

  logic [31:0] o_rdata, o_wr_addr, o_wr_data, o_rd_addr;
  logic [3:0]  o_wr_strb, o_cause;
  logic        o_trap, o_wr_seen;
  int          o_nstall, o_nreq, o_extra;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .RSV_GRAN_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .is_new(is_new), .mem_op(mem_op),
    .mem_size(mem_size), .is_unsigned(is_unsigned), .amo_fn(amo_fn), .addr(addr),
    .wdata(wdata), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .rdata(rdata), .stall(stall),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .rsv_valid(rsv_valid)
  );

  always #5 clk = ~clk;

  // Drives one instruction and acts as a zero-wait bus slave returning mem one cycle after accept.
  task automatic run_op(input logic [2:0] op, input logic [1:0] sz, input logic uns,
                        input logic [3:0] fn, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] mem);
    logic pend, fin;
    pend = 1'b0; fin = 1'b0;
    o_nstall = 0; o_nreq = 0; o_extra = 0; o_wr_seen = 1'b0; o_trap = 1'b0;
    o_cause = '0; o_rdata = '0; o_wr_addr = '0; o_wr_data = '0; o_wr_strb = '0; o_rd_addr = '0;
    @(negedge clk);
    valid = 1'b1; is_new = 1'b1; mem_op = op; mem_size = sz; is_unsigned = uns;
    amo_fn = fn; addr = a; wdata = wd; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    for (int c = 0; c < 16 && !fin; c++) begin
      #1;
      req_ready = req_valid;
      if (req_valid) begin
        o_nreq++;
        if (req_wen) begin
          o_wr_seen = 1'b1; o_wr_addr = req_addr; o_wr_data = req_wdata; o_wr_strb = req_wstrb;
        end else begin
          o_rd_addr = req_addr;
          pend = 1'b1;
        end
      end
      if (!stall) begin
        fin = 1'b1; o_rdata = rdata; o_trap = trap_valid; o_cause = trap_cause;
      end else begin
        o_nstall++;
        @(negedge clk);
        is_new = 1'b0; req_ready = 1'b0;
        resp_valid = pend; resp_rdata = pend ? mem : 32'h0; pend = 1'b0;
      end
    end
    if (!fin) o_nstall = 99;
    repeat (2) begin
      @(negedge clk);
      is_new = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
      #1;
      if (req_valid) o_extra++;
    end
    @(negedge clk);
    valid = 1'b0; mem_op = 3'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; is_new = 1'b0; mem_op = '0; mem_size = '0; is_unsigned = 1'b0;
    amo_fn = '0; addr = '0; wdata = '0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", req_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL rst_trap got %b exp 0", trap_valid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    checks++; if (rsv_valid !== 1'b0) begin errors++; $display("FAIL rst_rsv got %b exp 0", rsv_valid); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load;
    run_op(3'd1, 2'd0, 1'b0, 4'd0, 32'h1003, 32'h0, 32'h80FF_0000);
    checks++; if (o_rd_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr got %h exp 00001000", o_rd_addr); end
    checks++; if (o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", o_rdata); end
    checks++; if (o_nstall !== 3) begin errors++; $display("FAIL lb_stall got %0d exp 3", o_nstall); end
    checks++; if (o_extra !== 0) begin errors++; $display("FAIL lb_reissue got %0d exp 0", o_extra); end
    run_op(3'd1, 2'd0, 1'b1, 4'd0, 32'h1003, 32'h0, 32'h80FF_0000);
    checks++; if (o_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", o_rdata); end
    run_op(3'd1, 2'd1, 1'b0, 4'd0, 32'h1002, 32'h0, 32'h80FF_0000);
    checks++; if (o_rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_rdata got %h exp ffff80ff", o_rdata); end
    run_op(3'd1, 2'd1, 1'b1, 4'd0, 32'h1000, 32'h0, 32'h1234_ABCD);
    checks++; if (o_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu_rdata got %h exp 0000abcd", o_rdata); end
    run_op(3'd1, 2'd3, 1'b0, 4'd0, 32'h1004, 32'h0, 32'hCAFE_F00D);
    checks++; if (o_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ld_as_w got %h exp cafef00d", o_rdata); end
  endtask

  task automatic test_store;
    run_op(3'd2, 2'd1, 1'b0, 4'd0, 32'h2002, 32'h0000_ABCD, 32'h0);
    checks++; if (o_wr_seen !== 1'b1) begin errors++; $display("FAIL sh_wen got %b exp 1", o_wr_seen); end
    checks++; if (o_wr_strb !== 4'b1100) begin errors++; $display("FAIL sh_strb got %b exp 1100", o_wr_strb); end
    checks++; if (o_wr_data !== 32'hABCD_0000) begin errors++; $display("FAIL sh_wdata got %h exp abcd0000", o_wr_data); end
    checks++; if (o_wr_addr !== 32'h2000) begin errors++; $display("FAIL sh_addr got %h exp 00002000", o_wr_addr); end
    checks++; if (o_nstall !== 2) begin errors++; $display("FAIL sh_stall got %0d exp 2", o_nstall); end
    run_op(3'd2, 2'd0, 1'b0, 4'd0, 32'h2001, 32'h0000_005A, 32'h0);
    checks++; if (o_wr_strb !== 4'b0010) begin errors++; $display("FAIL sb_strb got %b exp 0010", o_wr_strb); end
    checks++; if (o_wr_data !== 32'h0000_5A00) begin errors++; $display("FAIL sb_wdata got %h exp 00005a00", o_wr_data); end
  endtask

  task automatic test_misaligned;
    run_op(3'd1, 2'd2, 1'b0, 4'd0, 32'h3002, 32'h0, 32'h0);
    checks++; if (o_trap !== 1'b1) begin errors++; $display("FAIL lw_mis_trap got %b exp 1", o_trap); end
    checks++; if (o_cause !== 4'd4) begin errors++; $display("FAIL lw_mis_cause got %0d exp 4", o_cause); end
    checks++; if (o_nreq + o_extra !== 0) begin errors++; $display("FAIL lw_mis_req got %0d exp 0", o_nreq + o_extra); end
    checks++; if (o_nstall !== 0) begin errors++; $display("FAIL lw_mis_stall got %0d exp 0", o_nstall); end
    run_op(3'd2, 2'd1, 1'b0, 4'd0, 32'h3001, 32'h0, 32'h0);
    checks++; if (o_cause !== 4'd6) begin errors++; $display("FAIL sh_mis_cause got %0d exp 6", o_cause); end
    run_op(3'd5, 2'd2, 1'b0, 4'd1, 32'h3002, 32'h0, 32'h0);
    checks++; if (o_cause !== 4'd6 || o_nreq !== 0) begin errors++; $display("FAIL amo_mis got cause %0d req %0d exp 6/0", o_cause, o_nreq); end
    run_op(3'd1, 2'd3, 1'b0, 4'd0, 32'h3002, 32'h0, 32'h0);
    checks++; if (o_trap !== 1'b1) begin errors++; $display("FAIL ld_as_w_mis got %b exp 1", o_trap); end
  endtask

  task automatic test_lr_sc;
    run_op(3'd3, 2'd2, 1'b0, 4'd0, 32'h4000, 32'h0, 32'h0000_0011);
    checks++; if (o_rdata !== 32'h11) begin errors++; $display("FAIL lr_rdata got %h exp 00000011", o_rdata); end
    checks++; if (rsv_valid !== 1'b1) begin errors++; $display("FAIL lr_rsv got %b exp 1", rsv_valid); end
    run_op(3'd4, 2'd2, 1'b0, 4'd0, 32'h4002, 32'h7, 32'h0);
    checks++; if (o_cause !== 4'd6 || rsv_valid !== 1'b1) begin errors++; $display("FAIL sc_mis got cause %0d rsv %b exp 6/1", o_cause, rsv_valid); end
    run_op(3'd4, 2'd2, 1'b0, 4'd0, 32'h4004, 32'h7, 32'h0);
    checks++; if (o_wr_seen !== 1'b1 || o_wr_data !== 32'h7) begin errors++; $display("FAIL sc_write got %b/%h exp 1/00000007", o_wr_seen, o_wr_data); end
    checks++; if (o_wr_strb !== 4'hF) begin errors++; $display("FAIL sc_strb got %h exp f", o_wr_strb); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL sc_ok_rdata got %h exp 0", o_rdata); end
    checks++; if (rsv_valid !== 1'b0) begin errors++; $display("FAIL sc_rsv_clr got %b exp 0", rsv_valid); end
    run_op(3'd4, 2'd2, 1'b0, 4'd0, 32'h4004, 32'h7, 32'h0);
    checks++; if (o_nreq !== 0) begin errors++; $display("FAIL sc2_req got %0d exp 0", o_nreq); end
    checks++; if (o_rdata !== 32'h1) begin errors++; $display("FAIL sc2_rdata got %h exp 1", o_rdata); end
    checks++; if (o_nstall !== 1) begin errors++; $display("FAIL sc2_stall got %0d exp 1", o_nstall); end
    run_op(3'd3, 2'd2, 1'b0, 4'd0, 32'h4000, 32'h0, 32'h0);
    run_op(3'd4, 2'd2, 1'b0, 4'd0, 32'h4008, 32'h7, 32'h0);
    checks++; if (o_rdata !== 32'h1 || o_nreq !== 0) begin errors++; $display("FAIL sc_gran got %h req %0d exp 1/0", o_rdata, o_nreq); end
  endtask

  task automatic test_amo;
    run_op(3'd5, 2'd2, 1'b0, 4'd6, 32'h6000, 32'h0000_0003, 32'hFFFF_FFFE);
    checks++; if (o_wr_data !== 32'h0000_0003) begin errors++; $display("FAIL amomax_w got %h exp 00000003", o_wr_data); end
    checks++; if (o_rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL amomax_rd got %h exp fffffffe", o_rdata); end
    checks++; if (o_nreq !== 2 || o_wr_addr !== 32'h6000 || o_wr_strb !== 4'hF) begin errors++; $display("FAIL amo_bus got req %0d addr %h strb %h exp 2/00006000/f", o_nreq, o_wr_addr, o_wr_strb); end
    checks++; if (o_nstall !== 4) begin errors++; $display("FAIL amo_stall got %0d exp 4", o_nstall); end
    run_op(3'd5, 2'd2, 1'b1, 4'd6, 32'h6000, 32'h0000_0003, 32'hFFFF_FFFE);
    checks++; if (o_wr_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL amomaxu_w got %h exp fffffffe", o_wr_data); end
    run_op(3'd5, 2'd2, 1'b0, 4'd5, 32'h6000, 32'h0000_0003, 32'hFFFF_FFFE);
    checks++; if (o_wr_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL amomin_w got %h exp fffffffe", o_wr_data); end
    run_op(3'd5, 2'd2, 1'b0, 4'd1, 32'h6004, 32'h0000_0010, 32'h0000_0005);
    checks++; if (o_wr_data !== 32'h0000_0015) begin errors++; $display("FAIL amoadd_w got %h exp 00000015", o_wr_data); end
  endtask

  task automatic test_snoop;
    run_op(3'd3, 2'd2, 1'b0, 4'd0, 32'h5000, 32'h0, 32'h0);
    run_op(3'd2, 2'd2, 1'b0, 4'd0, 32'h5000, 32'h55, 32'h0);
    run_op(3'd4, 2'd2, 1'b0, 4'd0, 32'h5000, 32'h9, 32'h0);
`ifdef MEM_ACCESS_RSV_SNOOP_EN
    checks++; if (o_rdata !== 32'h1 || o_nreq !== 0) begin errors++; $display("FAIL snoop_sc got %h req %0d exp 1/0", o_rdata, o_nreq); end
`else
    checks++; if (o_rdata !== 32'h0 || o_nreq !== 1) begin errors++; $display("FAIL snoop_sc got %h req %0d exp 0/1", o_rdata, o_nreq); end
`endif
  endtask

  task automatic test_flush;
    @(negedge clk);
    valid = 1'b1; is_new = 1'b1; mem_op = 3'd1; mem_size = 2'd2; is_unsigned = 1'b0;
    addr = 32'h7000; req_ready = 1'b0; resp_valid = 1'b0;
    @(negedge clk); is_new = 1'b0; #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL flush_req_on got %b exp 1", req_valid); end
    valid = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    @(negedge clk); #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL flush_req_off got %b exp 0", req_valid); end
    valid = 1'b1; is_new = 1'b1; addr = 32'h7004;
    @(negedge clk); is_new = 1'b0; #1; req_ready = req_valid;
    @(negedge clk); req_ready = 1'b0; valid = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_resp_stall got %b exp 0", stall); end
    @(negedge clk); resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF;
    @(negedge clk); resp_valid = 1'b0; mem_op = 3'd0;
    run_op(3'd1, 2'd2, 1'b0, 4'd0, 32'h7008, 32'h0, 32'h1234_5678);
    checks++; if (o_rdata !== 32'h1234_5678 || o_nstall !== 3) begin errors++; $display("FAIL flush_recover got %h stall %0d exp 12345678/3", o_rdata, o_nstall); end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    valid = 1'b1; is_new = 1'b1; mem_op = 3'd2; mem_size = 2'd2; addr = 32'h2000;
    wdata = 32'h1; req_ready = 1'b0;
    @(negedge clk); is_new = 1'b0; #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", req_valid); end
    rst_n = 1'b0; valid = 1'b0; #1;
    checks++; if (req_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL midrst got req %b stall %b exp 0/0", req_valid, stall); end
    @(negedge clk); rst_n = 1'b1; mem_op = 3'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_lr_sc();
    test_amo();
    test_snoop();
    test_flush();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor of the pipeline memory stage. Executes one load, store, LR, SC or AMO per instruction slot over a single-outstanding data-bus handshake.
- Additions over the previous generation:
  - XLEN of 32 or 64.
  - Byte-lane write strobes and lane alignment.
  - Misaligned-access trap generation.
  - A validity-tracked LR reservation.
  - Signed and unsigned AMO min/max.
- Sits between execute and writeback; stalls the pipeline while a bus transaction is in flight.

Parameters:
XLEN, 32, data width; 32 or 64 only.
ADDR_W, 32, address width.
RSV_GRAN_LOG2, 3, log2 of reservation granule in bytes (compare ignores the low bits).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid  in  1  slot holds a live instruction; inputs held stable while stall=1
is_new  in  1  first cycle of a new instruction in the slot
mem_op  in  3  0 none, 1 load, 2 store, 3 LR, 4 SC, 5 AMO
mem_size  in  2  0 B, 1 H, 2 W, 3 D (D legal only when XLEN=64)
is_unsigned  in  1  zero-extend loads; unsigned AMO min/max
amo_fn  in  4  0 swap, 1 add, 2 xor, 3 and, 4 or, 5 min, 6 max
addr  in  ADDR_W  effective address
wdata  in  XLEN  rs2 value
req_valid  out  1  bus request
req_ready  in  1  bus accepts request
req_wen  out  1  1 write, 0 read
req_addr  out  ADDR_W  XLEN/8-aligned address
req_wdata  out  XLEN  lane-shifted write data
req_wstrb  out  XLEN/8  byte enables
resp_valid  in  1  read data valid (single cycle, no back-pressure)
resp_rdata  in  XLEN  full aligned bus word
rdata  out  XLEN  result to writeback; valid when valid=1 and stall=0
stall  out  1  hold pipeline
trap_valid  out  1  misaligned-access trap
trap_cause  out  4  4 load misaligned; 6 store/AMO misaligned
rsv_valid  out  1  reservation currently held (debug/verification)

Behaviour:
- Reset: state IDLE. req_valid=0, stall=0, trap_valid=0, rdata=0, rsv_valid=0, done flag=0.
- Alignment:
  - Misaligned when addr mod (1<<mem_size) != 0.
  - The check runs combinationally in IDLE when valid=1 and mem_op!=0.
  - On misalignment: trap_valid=1 with cause (4 for load/LR, 6 for store/SC/AMO), no bus request, stall=0.
  - An SC that traps does not touch the reservation.
- Lanes: byte offset = addr mod (XLEN/8).
  - req_wdata = wdata << 8·offset.
  - req_wstrb = ((1<<(1<<mem_size))-1) << offset.
  - Load data = resp_rdata >> 8·offset, then sign- or zero-extended from 8/16/32 bits. D passes through unchanged.
  - mem_size=3 with XLEN=32 is treated as W.
- States:
  - IDLE: a new op goes to REQ; stall rises combinationally the same cycle.
  - REQ: req_valid=1.
    - On req_ready, a write (store, SC, AMO write phase) goes to FIN.
    - On req_ready, a read goes to RESP.
  - RESP: on resp_valid, capture the extracted data.
    - AMO: compute the new value, go to REQ with the write phase flagged.
    - Otherwise: go to FIN.
  - FIN: drop stall, set the done flag, return to IDLE. The done flag suppresses re-issue until is_new or !valid.
- Latency: minimum 2 cycles of stall for a store; 3 for a load (ready and resp in consecutive cycles).
- AMO:
  - Read, then write at the same address and strobes.
  - rdata = the original memory value.
  - For W on XLEN=64, operands are the low 32 bits sign-extended; min/max obey is_unsigned.
- Reservation:
  - LR sets rsv_valid=1 and rsv_addr=addr>>RSV_GRAN_LOG2 when its request is accepted.
  - SC with rsv_valid=1 and a matching granule performs the store; rdata=0.
  - SC that fails (including rsv_valid=0) issues no request; rdata=1, stall drops after 1 cycle.
  - Any SC clears rsv_valid.
- valid drop mid-transaction (flush):
  - In REQ, req_valid is deasserted the next cycle.
  - In RESP, the expected response is still consumed and discarded before returning to IDLE. stall stays 0 to the pipeline.
- Reset mid-operation: immediate return to IDLE; any in-flight bus transaction is abandoned.

Optional Feature:
- MEM_ACCESS_RSV_SNOOP_EN
  - Defined: any plain store or AMO accepted by the bus whose granule matches rsv_addr clears rsv_valid, so a subsequent SC fails.
  - Undefined: only SC clears the reservation; stores do not affect it.

Test Plan:
- XLEN=32, load B signed, addr=0x1003, resp_rdata=0x80FF_0000 -> req_addr=0x1000, rdata=0xFFFF_FF80, stall high 3 cycles.
- Store H, addr=0x2002, wdata=0x0000_ABCD -> req_wstrb=4'b1100, req_wdata=0xABCD_0000, req_wen=1.
- Load W at addr=0x3002 -> trap_valid=1, trap_cause=4, req_valid never asserts.
- LR addr=0x4000 then SC addr=0x4004 with wdata=7 -> SC writes 7 with req_wstrb=4'hF, rdata=0; a second SC -> no request, rdata=1.
- AMO max signed, mem=0xFFFF_FFFE, wdata=0x0000_0003 -> write phase data 0x0000_0003, rdata=0xFFFF_FFFE; with is_unsigned=1 the written data is 0xFFFF_FFFE.
- With MEM_ACCESS_RSV_SNOOP_EN: LR 0x5000, store 0x5000, SC 0x5000 -> SC fails with rdata=1; without the macro the SC succeeds with rdata=0.
